// File: rtl/morse_timer_pkg.sv
// Shared definitions for the Morse game interval timers: state encoding,
// mode constants and the default counter width.
package morse_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam int TC_W_DEFAULT = 7;

endpackage : morse_timer_pkg

// File: rtl/tick_interval_timer.sv
// Interval timer counting tick strobes up to a latched terminal count; periodic or one-shot.
// Build option: TICK_INTERVAL_TIMER_SIM_EN forces the latched terminal count to SIM_TC.
module tick_interval_timer
    import morse_timer_pkg::*;
#(
    parameter int TC_W   = TC_W_DEFAULT,
    parameter int SIM_TC = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            start,
    input  logic [TC_W-1:0] tc_in,
    input  logic            oneshot_in,
    input  logic            tick_in,
    output logic            timeout,
    output logic            busy,
    output logic            done,
    output logic [TC_W-1:0] count
);

    state_t          state_q, state_d;
    logic [TC_W-1:0] count_q, count_d;
    logic [TC_W-1:0] tc_q, tc_d;
    logic            mode_q, mode_d;
    logic            timeout_q, timeout_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [TC_W-1:0] tc_latch;
    logic [TC_W-1:0] tc_eff;
    logic            terminal;

`ifdef TICK_INTERVAL_TIMER_SIM_EN
    assign tc_latch = TC_W'(SIM_TC);
`else
    assign tc_latch = tc_in;
`endif

    // A terminal count of zero behaves like one so every tick fires.
    assign tc_eff   = (tc_q == '0) ? TC_W'(1) : tc_q;
    assign terminal = (count_q == tc_eff - TC_W'(1));

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        tc_d      = tc_q;
        mode_d    = mode_q;
        timeout_d = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (start) begin
            // Start beats a coincident tick and aborts any running interval silently.
            state_d = ST_RUN;
            count_d = '0;
            tc_d    = tc_latch;
            mode_d  = oneshot_in;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (tick_in) begin
                        if (terminal) begin
                            count_d   = '0;
                            timeout_d = 1'b1;
                            state_d   = (mode_q == MODE_ONESHOT) ? ST_DONE : ST_RUN;
                        end else begin
                            count_d = count_q + TC_W'(1);
                        end
                    end
                end
                default: begin
                    count_d = '0;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            tc_q      <= '0;
            mode_q    <= MODE_PERIODIC;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tc_q      <= tc_d;
            mode_q    <= mode_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign timeout = timeout_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign count   = count_q;

endmodule : tick_interval_timer

// File: tb/tb_tick_interval_timer.sv
// Self-checking bench for tick_interval_timer: per-cycle model comparison plus
// directed scenarios with hand-computed expectations.
module tb_tick_interval_timer;

    localparam int SIM_TC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       start = 1'b0;
    logic [6:0] tc_in = '0;
    logic       oneshot_in = 1'b0;
    logic       tick_in = 1'b0;
    logic       timeout;
    logic       busy;
    logic       done;
    logic [6:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    tick_interval_timer #(.TC_W(7), .SIM_TC(SIM_TC)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .start      (start),
        .tc_in      (tc_in),
        .oneshot_in (oneshot_in),
        .tick_in    (tick_in),
        .timeout    (timeout),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: an interval of m_period ticks, tracked as ticks elapsed.
    bit m_run, m_done, m_timeout, m_oneshot;
    int m_elapsed, m_period;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run = 0; m_done = 0; m_timeout = 0; m_oneshot = 0;
            m_elapsed = 0; m_period = 1;
        end else begin
            m_timeout = 0;
            if (!enable) begin
                m_run = 0; m_done = 0; m_elapsed = 0;
            end else if (start) begin
`ifdef TICK_INTERVAL_TIMER_SIM_EN
                m_period = SIM_TC;
`else
                m_period = (int'(tc_in) == 0) ? 1 : int'(tc_in);
`endif
                m_oneshot = oneshot_in;
                m_run = 1; m_done = 0; m_elapsed = 0;
            end else if (m_run && tick_in) begin
                m_elapsed = (m_elapsed + 1) % m_period;
                if (m_elapsed == 0) begin
                    m_timeout = 1;
                    if (m_oneshot) begin
                        m_run = 0; m_done = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_timeout", int'(timeout), int'(m_timeout));
        chk("model_busy",    int'(busy),    int'(m_run));
        chk("model_done",    int'(done),    int'(m_done));
        chk("model_count",   int'(count),   m_elapsed);
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic tick();
        tick_in = 1'b1;
        @(posedge clk); #1;
        tick_in = 1'b0;
    endtask

    task automatic do_start(input int tc, input bit os);
        tc_in = 7'(tc);
        oneshot_in = os;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        chk("reset_count", int'(count), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_timeout", int'(timeout), 0);
        enable = 1'b1;

`ifndef TICK_INTERVAL_TIMER_SIM_EN
        // Asynchronous reset mid-count
        do_start(10, 0);
        for (int i = 0; i < 5; i++) begin tick(); cyc(); end
        chk("pre_reset_count", int'(count), 5);
        #2 rst = 1'b0;
        #1;
        chk("async_reset_count", int'(count), 0);
        chk("async_reset_busy", int'(busy), 0);
        cyc();
        rst = 1'b1;
        cyc();
        chk("after_reset_busy", int'(busy), 0);
        tick();
        chk("idle_tick_ignored", int'(count), 0);
        cyc();

        // Periodic, tc=4
        do_start(4, 0);
        chk("periodic_busy_after_start", int'(busy), 1);
        chk("periodic_count_after_start", int'(count), 0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("periodic_count_t%0d", i), int'(count), i % 4);
            chk($sformatf("periodic_timeout_t%0d", i), int'(timeout), (i % 4 == 0) ? 1 : 0);
            chk($sformatf("periodic_busy_t%0d", i), int'(busy), 1);
            cyc();
            chk($sformatf("periodic_timeout_gap%0d", i), int'(timeout), 0);
        end

        // One-shot, tc=3
        do_start(3, 1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk($sformatf("oneshot_timeout_t%0d", i), int'(timeout), (i == 3) ? 1 : 0);
            chk($sformatf("oneshot_count_t%0d", i), int'(count), (i < 3) ? i : 0);
            chk($sformatf("oneshot_done_t%0d", i), int'(done), (i >= 3) ? 1 : 0);
            chk($sformatf("oneshot_busy_t%0d", i), int'(busy), (i >= 3) ? 0 : 1);
            cyc();
        end

        // Restart with coincident tick
        do_start(6, 0);
        for (int i = 0; i < 4; i++) begin tick(); cyc(); end
        chk("restart_pre_count", int'(count), 4);
        tick_in = 1'b1;
        do_start(2, 0);
        tick_in = 1'b0;
        chk("collision_count", int'(count), 0);
        chk("collision_timeout", int'(timeout), 0);
        chk("collision_busy", int'(busy), 1);
        cyc();
        tick();
        chk("restart_t1_count", int'(count), 1);
        chk("restart_t1_timeout", int'(timeout), 0);
        cyc();
        tick();
        chk("restart_t2_timeout", int'(timeout), 1);
        chk("restart_t2_count", int'(count), 0);
        cyc();

        // Enable drop during RUN
        do_start(5, 0);
        tick(); cyc(); tick(); cyc();
        chk("enable_pre_count", int'(count), 2);
        enable = 1'b0;
        tick_in = 1'b1;
        start = 1'b1;
        cyc();
        tick_in = 1'b0;
        start = 1'b0;
        chk("enable_drop_count", int'(count), 0);
        chk("enable_drop_busy", int'(busy), 0);
        chk("enable_drop_timeout", int'(timeout), 0);
        enable = 1'b1;
        cyc();

        // tc_in = 0 behaves as 1
        do_start(0, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("tc0_timeout_t%0d", i), int'(timeout), 1);
            chk($sformatf("tc0_count_t%0d", i), int'(count), 0);
            cyc();
        end
`else
        // Forced short terminal count
        do_start(100, 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("sim_timeout_t%0d", i), int'(timeout), (i == 3) ? 1 : 0);
            chk($sformatf("sim_count_t%0d", i), int'(count), i % 3);
            cyc();
        end
`endif

        cyc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_tick_interval_timer

// File: doc/tick_interval_timer.md
# tick_interval_timer

- Parametrised interval timer: counts single-cycle input ticks (e.g. the 1 ms strobe) up to a terminal count latched at start, then emits a one-cycle `timeout` pulse.
- Supports periodic and one-shot modes, a programmable terminal count, a busy/done status and a live count output.
- Sits between the 1 ms tick source and the Morse game control FSM. It replaces fixed-terminal counters used for dot, dash and gap durations.

## Interface
- `TC_W`, 7: width of terminal count and counter.
- `SIM_TC`, 3: terminal count forced when the simulation macro is defined.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `enable`  in  1  synchronous enable; low forces IDLE and clears count.
- `start`  in  1  one-cycle request that latches `tc_in` and `oneshot_in` and begins counting.
- `tc_in`  in  TC_W  terminal count in ticks.
- `oneshot_in`  in  1  1 = one-shot, 0 = periodic.
- `tick_in`  in  1  single-cycle tick strobe.
- `timeout`  out  1  one-cycle pulse when the interval elapses.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE (one-shot only).
- `count`  out  TC_W  current tick count.

## Operation
- **States:**
  - IDLE: counter held at 0.
  - RUN: counting ticks.
  - DONE: one-shot finished; counter held at 0.
- **IDLE → RUN:** on `start` with `enable`=1. Latch `tc_in` into `tc_q` and `oneshot_in` into `mode_q`; `count` goes to 0.
- **RUN:**
  - Each `tick_in` increments `count`.
  - On a tick with `count == tc_q-1`: `count` goes to 0 and `timeout` pulses.
  - Then periodic mode stays in RUN; one-shot mode goes to DONE.
- **DONE → RUN:** on `start`, with a fresh latch of `tc_in` and `oneshot_in`. Otherwise DONE holds.
- **Arithmetic:** unsigned, width `TC_W`.
  - `tc_q == 0` is treated as 1: every tick fires.
  - Maximum interval is 2^TC_W − 1 ticks. No overflow is possible because the counter wraps at `tc_q-1`.
- **Boundary conditions:**
  - `start` and `tick_in` in the same cycle: start wins, tick discarded, `count`=0.
  - `start` in RUN: restart immediately with new values; no `timeout` for the aborted interval.
  - `enable` low, in any state: next edge gives IDLE, `count`=0, `timeout`=0, `done`=0. Start is ignored while `enable`=0.
  - `tick_in` outside RUN: ignored.
  - `tc_in` and `oneshot_in` changing during RUN: no effect until the next `start`.
  - `rst` asserted mid-interval: immediate return to reset values, independent of clock.

## Timing
- Reset values: state IDLE, `count`=0, `timeout`=0, `busy`=0, `done`=0, `tc_q`=0, `mode_q`=0.
- All outputs are registered.
- `start` sampled at edge N gives `busy`=1 from N+1.
- The terminal tick sampled at edge N gives `timeout`=1 during cycle N+1 only, with `count`=0 in the same cycle.
  - One-shot: `busy`=0 and `done`=1 from N+1.
- `timeout` is never high for two consecutive cycles. Ticks are assumed at least 2 clocks apart; back-to-back ticks with `tc_q`=1 give back-to-back pulses.
- Latency from the first counted tick to `timeout` is `tc_q` ticks plus 1 clock.

## Configuration
- Macro: `TICK_INTERVAL_TIMER_SIM_EN`.
- **Defined:** the latched terminal count is forced to `SIM_TC`, ignoring `tc_in`. This gives short intervals for simulation benches of the game FSM.
- **Undefined:** `tc_in` is latched as specified.
- All other behaviour is identical in both builds.

## Structure
- Shared package `morse_timer_pkg` holds:
  - the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the mode constants `MODE_PERIODIC`=1'b0 and `MODE_ONESHOT`=1'b1;
  - the default `TC_W`.
- No sub-module: a single FSM plus counter in one module. Multiple instances (dot, dash, gap) are instantiated by the parent.

## Test plan
- **Reset:** assert `rst`=0 mid-count (`count`=5) → all outputs 0 asynchronously; after release, state IDLE.
- **Periodic:** `tc_in`=4, `oneshot_in`=0, start, 12 ticks → `timeout` pulses after ticks 4, 8 and 12. `count` sequence 1,2,3,0 repeating; `busy` stays 1.
- **One-shot:** `tc_in`=3, `oneshot_in`=1, 5 ticks → one `timeout` after tick 3, then `done`=1 and `busy`=0. Ticks 4 and 5 are ignored and `count` stays 0.
- **Restart and collision:** `tc_in`=6, 4 ticks, then `start` coincident with a tick, `tc_in`=2 → `count`=0 and no pulse in that cycle. The next 2 ticks give `timeout`.
- **Enable drop and `tc_in`=0:**
  - `enable`=0 during RUN at `count`=2 → IDLE, `count`=0 next cycle, no `timeout`.
  - Then `enable`=1, `tc_in`=0, start, 3 ticks → 3 pulses.
- **Sim macro:** with `TICK_INTERVAL_TIMER_SIM_EN` and `tc_in`=100 → `timeout` after 3 ticks.
